// File: rtl/regfile_pkg.sv
// Shared types and defaults for the swap-capable register file.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWAP2 = 1'b1
    } swp_state_t;

    localparam int DEF_W     = 8;
    localparam int DEF_D     = 4;
    localparam int DEF_IMM_W = 6;

    // Keep only the low imm_w bits of imm. Callers cast the result down
    // to the data width.
    function automatic logic [63:0] zext_imm(input logic [63:0] imm, input int imm_w);
        logic [63:0] mask;
        mask = (imm_w >= 64) ? '1 : ((64'd1 << imm_w) - 64'd1);
        return imm & mask;
    endfunction

endpackage

// File: rtl/regfile_swp.sv
// Register file: 3 combinational read ports, 1 write port, load-immediate, atomic 2-cycle swap.
// Latency: reads 0 cycles; writes/LIM visible after 1 edge; swap fully visible after 2 edges.
// Backpressure: Busy high during SWAP2; every request in that cycle is dropped, so control must stall.
//
// Ports: Clk/Reset (async, active-high); ReadAddrA/B/C -> DataOutA/B/C;
//        WriteEn/WriteAddr/DataIn; LimEn/Imm (writes LIM_REG);
//        SwapReq/SwapAddrX/SwapAddrY; Busy, SwapDone status.
// Optional macro REGFILE_BYPASS_EN: write-through of the accepted write/LIM value to matching read ports.
module regfile_swp
    import regfile_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int D       = DEF_D,
    parameter int IMM_W   = DEF_IMM_W,
    parameter int LIM_REG = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [D-1:0]     ReadAddrA,
    input  logic [D-1:0]     ReadAddrB,
    input  logic [D-1:0]     ReadAddrC,
    output logic [W-1:0]     DataOutA,
    output logic [W-1:0]     DataOutB,
    output logic [W-1:0]     DataOutC,
    input  logic             WriteEn,
    input  logic [D-1:0]     WriteAddr,
    input  logic [W-1:0]     DataIn,
    input  logic             LimEn,
    input  logic [IMM_W-1:0] Imm,
    input  logic             SwapReq,
    input  logic [D-1:0]     SwapAddrX,
    input  logic [D-1:0]     SwapAddrY,
    output logic             Busy,
    output logic             SwapDone
);

    localparam int            DEPTH    = 2 ** D;
    localparam logic [D-1:0]  LIM_ADDR = D'(LIM_REG);

    logic [W-1:0] regs [DEPTH];
    logic [W-1:0] temp;
    logic [D-1:0] y_lat;
    logic [W-1:0] lim_val;

    swp_state_t state, state_nxt;

    assign lim_val = W'(zext_imm(64'(Imm), IMM_W));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (SwapReq) state_nxt = SWAP2;
            SWAP2:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Busy is decoded straight from the state flop, so it is registered
    // and high for exactly the SWAP2 cycle.
    assign Busy = (state == SWAP2);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            temp     <= '0;
            y_lat    <= '0;
            state    <= IDLE;
            SwapDone <= 1'b0;
        end else begin
            state    <= state_nxt;
            SwapDone <= (state == SWAP2);
            if (state == IDLE) begin
                // Single accepted request per edge: SwapReq > LimEn > WriteEn.
                if (SwapReq) begin
                    temp            <= regs[SwapAddrX];
                    regs[SwapAddrX] <= regs[SwapAddrY];
                    y_lat           <= SwapAddrY;
                end else if (LimEn) begin
                    regs[LIM_ADDR]  <= lim_val;
                end else if (WriteEn) begin
                    regs[WriteAddr] <= DataIn;
                end
            end else begin
                // For X==Y this restores the original value.
                regs[y_lat] <= temp;
            end
        end
    end

    logic [D-1:0] rd_addr [3];
    logic [W-1:0] rd_dat  [3];

    assign rd_addr[0] = ReadAddrA;
    assign rd_addr[1] = ReadAddrB;
    assign rd_addr[2] = ReadAddrC;
    assign DataOutA   = rd_dat[0];
    assign DataOutB   = rd_dat[1];
    assign DataOutC   = rd_dat[2];

`ifdef REGFILE_BYPASS_EN
    logic lim_fwd;
    logic wr_fwd;
    assign lim_fwd = (state == IDLE) && !SwapReq && LimEn;
    assign wr_fwd  = (state == IDLE) && !SwapReq && !LimEn && WriteEn;
`endif

    for (genvar p = 0; p < 3; p++) begin : g_rd
`ifdef REGFILE_BYPASS_EN
        always_comb begin
            rd_dat[p] = regs[rd_addr[p]];
            if (lim_fwd && (rd_addr[p] == LIM_ADDR))
                rd_dat[p] = lim_val;
            else if (wr_fwd && (rd_addr[p] == WriteAddr))
                rd_dat[p] = DataIn;
        end
`else
        assign rd_dat[p] = regs[rd_addr[p]];
`endif
    end

endmodule

// File: tb/tb_regfile_swp.sv
// Self-checking bench for regfile_swp (default parameters).
// Directed table, hand-written corner sequences, then random traffic against a reference model.
module tb_regfile_swp;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [3:0] ReadAddrA, ReadAddrB, ReadAddrC;
    logic [7:0] DataOutA, DataOutB, DataOutC;
    logic       WriteEn;
    logic [3:0] WriteAddr;
    logic [7:0] DataIn;
    logic       LimEn;
    logic [5:0] Imm;
    logic       SwapReq;
    logic [3:0] SwapAddrX, SwapAddrY;
    logic       Busy, SwapDone;

    int checks = 0;
    int errors = 0;

    regfile_swp dut (
        .Clk(Clk), .Reset(Reset),
        .ReadAddrA(ReadAddrA), .ReadAddrB(ReadAddrB), .ReadAddrC(ReadAddrC),
        .DataOutA(DataOutA), .DataOutB(DataOutB), .DataOutC(DataOutC),
        .WriteEn(WriteEn), .WriteAddr(WriteAddr), .DataIn(DataIn),
        .LimEn(LimEn), .Imm(Imm),
        .SwapReq(SwapReq), .SwapAddrX(SwapAddrX), .SwapAddrY(SwapAddrY),
        .Busy(Busy), .SwapDone(SwapDone)
    );

    always #5 Clk = ~Clk;

    // Reference model: register array plus one pending-swap record.
    logic [7:0] m [16];
    bit         pend;
    logic [3:0] pend_y;
    logic [7:0] pend_v;
    bit         exp_done;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m[i] = 8'h00;
        pend     = 1'b0;
        exp_done = 1'b0;
    endtask

    task automatic idle_inputs();
        WriteEn = 1'b0; LimEn = 1'b0; SwapReq = 1'b0;
    endtask

    // Apply one clock edge: update model from current inputs, wait edge,
    // drop the enables and compare all outputs.
    task automatic tick();
        exp_done = pend;
        if (pend) begin
            m[pend_y] = pend_v;
            pend      = 1'b0;
        end else if (SwapReq) begin
            pend_v       = m[SwapAddrX];
            pend_y       = SwapAddrY;
            m[SwapAddrX] = m[SwapAddrY];
            pend         = 1'b1;
        end else if (LimEn) begin
            m[0] = {2'b00, Imm};
        end else if (WriteEn) begin
            m[WriteAddr] = DataIn;
        end
        @(posedge Clk);
        #1;
        idle_inputs();
        #1;
        chk("rdA",  DataOutA, m[ReadAddrA]);
        chk("rdB",  DataOutB, m[ReadAddrB]);
        chk("rdC",  DataOutC, m[ReadAddrC]);
        chk("busy", 8'(Busy), 8'(pend));
        chk("done", 8'(SwapDone), 8'(exp_done));
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        WriteEn = 1'b1; WriteAddr = a; DataIn = d;
        tick();
    endtask

    task automatic swap(input logic [3:0] x, input logic [3:0] y);
        SwapReq = 1'b1; SwapAddrX = x; SwapAddrY = y;
        tick();
    endtask

    // Asynchronous reset pulse placed mid-cycle.
    task automatic async_reset();
        #2 Reset = 1'b1;
        #1;
        chk("rst_rdA", DataOutA, 8'h00);
        chk("rst_busy", 8'(Busy), 8'h00);
        chk("rst_done", 8'(SwapDone), 8'h00);
        Reset = 1'b0;
        model_clear();
    endtask

    typedef struct {
        bit         we;
        logic [3:0] wa;
        logic [7:0] din;
        bit         lim;
        logic [5:0] imm;
        bit         swp;
        logic [3:0] sx;
        logic [3:0] sy;
        logic [3:0] ra;
        logic [7:0] exp_a;
        bit         exp_busy;
        bit         exp_done;
    } vec_t;

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{1, 4'd7, 8'hC3, 0, 6'h00, 0, 4'd0, 4'd0, 4'd7, 8'hC3, 0, 0};
        tbl[1]  = '{1, 4'd2, 8'h11, 0, 6'h00, 0, 4'd0, 4'd0, 4'd2, 8'h11, 0, 0};
        tbl[2]  = '{1, 4'd9, 8'hEE, 0, 6'h00, 0, 4'd0, 4'd0, 4'd9, 8'hEE, 0, 0};
        tbl[3]  = '{0, 4'd0, 8'h00, 0, 6'h00, 1, 4'd2, 4'd9, 4'd2, 8'hEE, 1, 0};
        tbl[4]  = '{1, 4'd4, 8'h77, 0, 6'h00, 0, 4'd0, 4'd0, 4'd9, 8'h11, 0, 1};
        tbl[5]  = '{0, 4'd0, 8'h00, 0, 6'h00, 0, 4'd0, 4'd0, 4'd4, 8'h00, 0, 0};
        tbl[6]  = '{1, 4'd4, 8'h77, 0, 6'h00, 0, 4'd0, 4'd0, 4'd4, 8'h77, 0, 0};
        tbl[7]  = '{1, 4'd0, 8'hFF, 1, 6'h2A, 0, 4'd0, 4'd0, 4'd0, 8'h2A, 0, 0};
        tbl[8]  = '{1, 4'd3, 8'h99, 1, 6'h15, 1, 4'd0, 4'd7, 4'd0, 8'hC3, 1, 0};
        tbl[9]  = '{0, 4'd0, 8'h00, 0, 6'h00, 0, 4'd0, 4'd0, 4'd7, 8'h2A, 0, 1};
        tbl[10] = '{0, 4'd0, 8'h00, 0, 6'h00, 0, 4'd0, 4'd0, 4'd3, 8'h00, 0, 0};
        tbl[11] = '{0, 4'd0, 8'h00, 1, 6'h3F, 0, 4'd0, 4'd0, 4'd0, 8'h3F, 0, 0};
        tbl[12] = '{1, 4'd0, 8'hFF, 0, 6'h00, 0, 4'd0, 4'd0, 4'd0, 8'hFF, 0, 0};

        Reset = 1'b1;
        idle_inputs();
        WriteAddr = 4'd0; DataIn = 8'h00; Imm = 6'h00;
        SwapAddrX = 4'd0; SwapAddrY = 4'd0;
        ReadAddrA = 4'd0; ReadAddrB = 4'd0; ReadAddrC = 4'd0;
        model_clear();
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;

        // Reset state of every register and status output.
        #1;
        for (int i = 0; i < 16; i++) begin
            ReadAddrC = 4'(i);
            #1 chk("reset_reg", DataOutC, 8'h00);
        end
        chk("reset_busy", 8'(Busy), 8'h00);
        chk("reset_done", 8'(SwapDone), 8'h00);

        // Before-edge visibility of a pending write.
        WriteEn = 1'b1; WriteAddr = 4'd7; DataIn = 8'hC3; ReadAddrB = 4'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("pre_edge_rdB", DataOutB, 8'hC3);
`else
        chk("pre_edge_rdB", DataOutB, 8'h00);
`endif
        idle_inputs();

        // Directed table.
        for (int i = 0; i < 13; i++) begin
            WriteEn = tbl[i].we; WriteAddr = tbl[i].wa; DataIn = tbl[i].din;
            LimEn = tbl[i].lim; Imm = tbl[i].imm;
            SwapReq = tbl[i].swp; SwapAddrX = tbl[i].sx; SwapAddrY = tbl[i].sy;
            ReadAddrA = tbl[i].ra;
            ReadAddrB = 4'($urandom_range(0, 15));
            ReadAddrC = 4'($urandom_range(0, 15));
            tick();
            chk($sformatf("tbl%0d_a", i), DataOutA, tbl[i].exp_a);
            chk($sformatf("tbl%0d_busy", i), 8'(Busy), 8'(tbl[i].exp_busy));
            chk($sformatf("tbl%0d_done", i), 8'(SwapDone), 8'(tbl[i].exp_done));
        end

        // Asynchronous reset clears a freshly written register.
        ReadAddrA = 4'd3;
        wr(4'd3, 8'h5A);
        chk("r3_written", DataOutA, 8'h5A);
        async_reset();

        // Reset in the middle of a swap: no completion pulse afterwards.
        wr(4'd2, 8'h11);
        wr(4'd9, 8'hEE);
        ReadAddrA = 4'd2; ReadAddrB = 4'd9;
        swap(4'd2, 4'd9);
        chk("mid_swap_busy", 8'(Busy), 8'h01);
        chk("mid_swap_r2", DataOutA, 8'hEE);
        chk("mid_swap_r9", DataOutB, 8'hEE);
        async_reset();
        chk("rst_swap_r9", DataOutB, 8'h00);
        tick();
        chk("rst_swap_nodone", 8'(SwapDone), 8'h00);

        // X == Y swap leaves the value unchanged, SwapDone pulses once.
        ReadAddrA = 4'd5;
        wr(4'd5, 8'h33);
        swap(4'd5, 4'd5);
        chk("xy_busy", 8'(Busy), 8'h01);
        tick();
        chk("xy_done", 8'(SwapDone), 8'h01);
        chk("xy_val", DataOutA, 8'h33);
        tick();
        chk("xy_done_once", 8'(SwapDone), 8'h00);

        // SwapReq held high: one swap per two edges.
        wr(4'd1, 8'hA1);
        wr(4'd6, 8'hB6);
        ReadAddrA = 4'd1; ReadAddrB = 4'd6;
        for (int k = 0; k < 4; k++) swap(4'd1, 4'd6);
        chk("b2b_r1", DataOutA, 8'hA1);
        chk("b2b_r6", DataOutB, 8'hB6);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            WriteEn   = ($urandom_range(0, 1) == 1);
            WriteAddr = 4'($urandom_range(0, 15));
            DataIn    = 8'($urandom);
            LimEn     = ($urandom_range(0, 4) == 0);
            Imm       = 6'($urandom);
            SwapReq   = ($urandom_range(0, 3) == 0);
            SwapAddrX = 4'($urandom_range(0, 15));
            SwapAddrY = 4'($urandom_range(0, 15));
            ReadAddrA = 4'($urandom_range(0, 15));
            ReadAddrB = 4'($urandom_range(0, 15));
            ReadAddrC = 4'($urandom_range(0, 15));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
